// File: rtl/cordic_sequencer_if.sv
// Handshake and control bundle between a CORDIC vectoring datapath owner and its sequencer.
// The master drives the requests and y sign; the slave (sequencer) drives the mux, load and status lines.
interface cordic_sequencer_if #(
    parameter int CNT_WIDTH = 4
);
    logic                 start;
    logic                 abort;
    logic                 y_sign;
    logic [1:0]           sel;
    logic                 ld_en;
    logic [CNT_WIDTH-1:0] iter;
    logic                 dir;
    logic                 busy;
    logic                 done;

    modport master (
        output start, abort, y_sign,
        input  sel, ld_en, iter, dir, busy, done
    );

    modport slave (
        input  start, abort, y_sign,
        output sel, ld_en, iter, dir, busy, done
    );
endinterface

// File: rtl/cordic_sequencer.sv
// Control FSM for an iterative CORDIC vectoring unit: one operand load, ITERATIONS
// micro-rotations steered by the sign of y, then a single-cycle done pulse.
module cordic_sequencer #(
    parameter int ITERATIONS = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cordic_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(ITERATIONS - 1);
    localparam logic [1:0] SEL_EXT  = 2'd0;
    localparam logic [1:0] SEL_ITER = 2'd1;
    localparam logic [1:0] SEL_HOLD = 2'd2;

    state_t               state_reg;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] cnt_reg;
    logic [CNT_WIDTH-1:0] cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (bus.start && !bus.abort) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                cnt_next   = '0;
                state_next = bus.abort ? IDLE : ITER;
            end
            ITER: begin
                if (bus.abort) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == LAST_ITER) begin
                    // Saturate on the last index; the counter is cleared on the way back to IDLE.
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Everything but dir is a pure decode of state and counter; dir follows y_sign with no register.
    always_comb begin
        bus.sel   = SEL_HOLD;
        bus.ld_en = 1'b0;
        bus.iter  = '0;
        bus.dir   = 1'b0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state_reg)
            LOAD: begin
                bus.sel   = SEL_EXT;
                bus.ld_en = 1'b1;
                bus.busy  = 1'b1;
            end
            ITER: begin
                bus.sel   = SEL_ITER;
                bus.ld_en = 1'b1;
                bus.busy  = 1'b1;
                bus.iter  = cnt_reg;
                bus.dir   = ~bus.y_sign;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                bus.sel = SEL_HOLD;
            end
        endcase
    end
endmodule

// File: tb/tb_cordic_sequencer.sv
// Directed bench: a vector table for the 16-iteration sequencer plus hand-written
// sequences for asynchronous reset and a 2-iteration instance.
module tb_cordic_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cordic_sequencer_if #(.CNT_WIDTH(4)) bus16 ();
    cordic_sequencer_if #(.CNT_WIDTH(1)) bus2 ();

    cordic_sequencer #(.ITERATIONS(16), .CNT_WIDTH(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(bus16)
    );
    cordic_sequencer #(.ITERATIONS(2), .CNT_WIDTH(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2)
    );

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_ITER = 2;
    localparam int P_DONE = 3;

    typedef struct {
        logic       start;
        logic       abort;
        logic       y_sign;
        logic [1:0] sel;
        logic       ld_en;
        logic [3:0] iter;
        logic       dir;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Expected outputs for each phase, written out by hand.
    task automatic add(input logic st, input logic ab, input logic ys, input int phase, input int it);
        vec_t v;
        v.start  = st;
        v.abort  = ab;
        v.y_sign = ys;
        v.sel    = 2'd2;
        v.ld_en  = 1'b0;
        v.iter   = 4'd0;
        v.dir    = 1'b0;
        v.busy   = 1'b0;
        v.done   = 1'b0;
        case (phase)
            P_LOAD: begin v.sel = 2'd0; v.ld_en = 1'b1; v.busy = 1'b1; end
            P_ITER: begin
                v.sel = 2'd1; v.ld_en = 1'b1; v.busy = 1'b1;
                v.iter = 4'(it); v.dir = ~ys;
            end
            P_DONE: v.done = 1'b1;
            default: v.sel = 2'd2;
        endcase
        vecs.push_back(v);
    endtask

    task automatic check16(input string tag, input vec_t e);
        chk({tag, ".sel"},   int'(bus16.sel),   int'(e.sel));
        chk({tag, ".ld_en"}, int'(bus16.ld_en), int'(e.ld_en));
        chk({tag, ".iter"},  int'(bus16.iter),  int'(e.iter));
        chk({tag, ".dir"},   int'(bus16.dir),   int'(e.dir));
        chk({tag, ".busy"},  int'(bus16.busy),  int'(e.busy));
        chk({tag, ".done"},  int'(bus16.done),  int'(e.done));
    endtask

    task automatic check2(input string tag, input int sel, input int ld, input int it,
                          input int dr, input int bs, input int dn);
        chk({tag, ".sel"},   int'(bus2.sel),   sel);
        chk({tag, ".ld_en"}, int'(bus2.ld_en), ld);
        chk({tag, ".iter"},  int'(bus2.iter),  it);
        chk({tag, ".dir"},   int'(bus2.dir),   dr);
        chk({tag, ".busy"},  int'(bus2.busy),  bs);
        chk({tag, ".done"},  int'(bus2.done),  dn);
    endtask

    initial begin
        vec_t idle_v;
        bus16.start = 1'b0; bus16.abort = 1'b0; bus16.y_sign = 1'b0;
        bus2.start  = 1'b0; bus2.abort  = 1'b0; bus2.y_sign  = 1'b0;

        // Nominal run; start pulse in ITER and start+abort in DONE must be ignored.
        add(1, 0, 0, P_IDLE, 0);
        add(0, 0, 0, P_LOAD, 0);
        for (int i = 0; i < 16; i++) add(logic'(i == 3), 0, logic'(i % 2), P_ITER, i);
        add(1, 1, 0, P_DONE, 0);
        add(0, 0, 0, P_IDLE, 0);
        // Abort at iter 7, then start+abort in IDLE stays in IDLE.
        add(1, 0, 0, P_IDLE, 0);
        add(0, 0, 0, P_LOAD, 0);
        for (int i = 0; i < 8; i++) add(0, logic'(i == 7), 1, P_ITER, i);
        add(1, 1, 0, P_IDLE, 0);
        add(1, 1, 0, P_IDLE, 0);
        add(0, 0, 0, P_IDLE, 0);
        // Abort during LOAD.
        add(1, 0, 0, P_IDLE, 0);
        add(0, 1, 0, P_LOAD, 0);
        add(0, 0, 0, P_IDLE, 0);
        // start held high for 40 cycles: done at rows 18 and 37, one IDLE row between.
        for (int r = 0; r < 40; r++) begin
            int p;
            p = r % 19;
            if (p == 0)       add(1, 0, 0, P_IDLE, 0);
            else if (p == 1)  add(1, 0, 0, P_LOAD, 0);
            else if (p == 18) add(1, 0, 0, P_DONE, 0);
            else              add(1, 0, 0, P_ITER, p - 2);
        end
        add(0, 1, 0, P_ITER, 0);
        add(0, 0, 0, P_IDLE, 0);

        // Reset values while rst_n is low, before any clock edge.
        add(0, 0, 0, P_IDLE, 0);
        idle_v = vecs.pop_back();
        #1;
        check16("reset", idle_v);
        check2("reset2", 2, 0, 0, 0, 0, 0);
        $display("reset: sel=%0d busy=%0d iter=%0d", bus16.sel, bus16.busy, bus16.iter);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            bus16.start  = vecs[i].start;
            bus16.abort  = vecs[i].abort;
            bus16.y_sign = vecs[i].y_sign;
            #1;
            check16($sformatf("row%0d", i), vecs[i]);
            $display("row %0d start=%0b abort=%0b ys=%0b -> sel=%0d ld=%0b iter=%0d dir=%0b busy=%0b done=%0b",
                     i, vecs[i].start, vecs[i].abort, vecs[i].y_sign, bus16.sel, bus16.ld_en,
                     bus16.iter, bus16.dir, bus16.busy, bus16.done);
        end

        // Asynchronous reset while at iter 5.
        @(posedge clk); #1;
        bus16.start = 1'b1; bus16.abort = 1'b0; bus16.y_sign = 1'b0;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre_reset.iter", int'(bus16.iter), 5);
        chk("pre_reset.busy", int'(bus16.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check16("async_reset", idle_v);
        $display("async reset at iter 5: sel=%0d ld=%0b busy=%0b iter=%0d", bus16.sel, bus16.ld_en,
                 bus16.busy, bus16.iter);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #2;
            chk($sformatf("post_reset%0d.done", c), int'(bus16.done), 0);
            chk($sformatf("post_reset%0d.busy", c), int'(bus16.busy), 0);
        end
        $display("post-reset: 20 idle cycles, no done pulse");

        // Two-iteration instance: LOAD, iter 0 and 1, done in cycle 4.
        @(posedge clk); #1;
        bus2.start = 1'b1; bus2.y_sign = 1'b0; #1;
        check2("n2.c0", 2, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        bus2.start = 1'b0; #1;
        check2("n2.c1", 0, 1, 0, 0, 1, 0);
        @(posedge clk); #1;
        bus2.y_sign = 1'b1; #1;
        check2("n2.c2", 1, 1, 0, 0, 1, 0);
        @(posedge clk); #1;
        bus2.y_sign = 1'b0; #1;
        check2("n2.c3", 1, 1, 1, 1, 1, 0);
        @(posedge clk); #2;
        check2("n2.c4", 2, 0, 0, 0, 0, 1);
        @(posedge clk); #2;
        check2("n2.c5", 2, 0, 0, 0, 0, 0);
        $display("two-iteration op: done observed in cycle 4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=0 expected=1");
        $fatal(1, "timeout");
    end
endmodule
